// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the serial adder/subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // Number of RUN cycles needed to sweep an operand of the given width.
    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple slice of full-adder cells.
// Latency: combinational.
// Backpressure: none.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co   = c[CHUNK];
    // Carry into the slice MSB; only meaningful for the top slice's overflow.
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract, CHUNK bits per clock through one ripple slice.
// Latency: N = WIDTH/CHUNK cycles from accept to out_valid.
// Backpressure: result held in DONE until out_ready; no input accepted until then.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = chunk_count(WIDTH, CHUNK);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("serial_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IW-1:0]    idx;
    int               base;

    logic [CHUNK-1:0] sl_a;
    logic [CHUNK-1:0] sl_b;
    logic [CHUNK-1:0] sl_s;
    logic             sl_co;
    logic             sl_cmsb;

    assign base = int'(idx) * CHUNK;
    assign sl_a = a_q[base +: CHUNK];
    assign sl_b = b_q[base +: CHUNK];

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (sl_a),
        .b    (sl_b),
        .ci   (carry),
        .s    (sl_s),
        .co   (sl_co),
        .cmsb (sl_cmsb)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract as a + ~b + ~cin so borrow-in maps onto carry-in.
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        idx   <= '0;
                        sum   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: CHUNK] <= sl_s;
                    carry              <= sl_co;
                    if (idx == LAST) begin
                        cout  <= sl_co;
                        ovf   <= sl_cmsb ^ sl_co;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
